// File: rtl/game_pkg.sv
// Shared types and defaults for the NOT-NOT game: round state encoding and
// default timing constants used by the controller, judge and instruction units.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_NEW_INSTR = 3'd1,
        ST_WAIT_KEY  = 3'd2,
        ST_KEY_HELD  = 3'd3,
        ST_JUDGE     = 3'd4,
        ST_CORRECT   = 3'd5,
        ST_WRONG     = 3'd6,
        ST_GAME_OVER = 3'd7
    } game_state_t;

    localparam int DEF_LIVES        = 3;
    localparam int DEF_ANSWER_CYC   = 50_000_000;
    localparam int DEF_FEEDBACK_CYC = 25_000_000;
    localparam int DEF_SCORE_W      = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_ctrl_cycle_timer.sv
// Loadable down-counter that holds at zero; times both the answer window and
// the feedback display.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Count register: load has priority, decrement stops at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != {W{1'b0}})) begin
            r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {W{1'b0}});

endmodule

// File: rtl/game_ctrl.sv
// NOT-NOT round controller: sequences instruction issue, answer window, judging
// and feedback, and keeps score and remaining lives for the current game.
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES        = DEF_LIVES,
    parameter int ANSWER_CYC   = DEF_ANSWER_CYC,
    parameter int FEEDBACK_CYC = DEF_FEEDBACK_CYC,
    parameter int SCORE_W      = DEF_SCORE_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       key_pressed,
    input  logic                       answer,
    output logic                       change_instruction,
    output logic                       prepare_judge,
    output logic                       judge_strobe,
    output logic                       no_press,
    output logic                       decrease_life,
    output logic                       fb_correct,
    output logic                       fb_wrong,
    output logic [SCORE_W-1:0]         score,
    output logic [$clog2(LIVES+1)-1:0] lives,
    output logic                       game_over
);

    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int TMR_RAW = $clog2(max_int(ANSWER_CYC, FEEDBACK_CYC));
    localparam int TMR_W   = (TMR_RAW < 1) ? 1 : TMR_RAW;

    localparam logic [TMR_W-1:0]   ANS_LOAD   = TMR_W'(ANSWER_CYC - 1);
    localparam logic [TMR_W-1:0]   FB_LOAD    = TMR_W'(FEEDBACK_CYC - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    game_state_t        r_state;
    game_state_t        w_next;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_en;
    logic               w_tmr_zero;
    logic               w_game_start;
    logic [SCORE_W-1:0] r_score;
    logic [LIVES_W-1:0] r_lives;
    logic               r_no_press;
    logic               r_decrease_life;

    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    assign w_game_start = ((r_state == ST_IDLE) || (r_state == ST_GAME_OVER)) && start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and timer control
    always_comb begin
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = {TMR_W{1'b0}};
        w_tmr_en   = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    w_next = ST_NEW_INSTR;
                end else begin
                    w_next = r_state;
                end
            end
            ST_NEW_INSTR: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = ANS_LOAD;
                w_next     = ST_WAIT_KEY;
            end
            ST_WAIT_KEY: begin
                w_tmr_en = 1'b1;
                // A press on the final window cycle still counts as a press
                if (key_pressed) begin
                    w_next = ST_KEY_HELD;
                end else if (w_tmr_zero) begin
                    w_next = ST_JUDGE;
                end else begin
                    w_next = ST_WAIT_KEY;
                end
            end
            ST_KEY_HELD: begin
                if (!key_pressed) begin
                    w_next = ST_JUDGE;
                end else begin
                    w_next = ST_KEY_HELD;
                end
            end
            ST_JUDGE: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = FB_LOAD;
                if (answer) begin
                    w_next = ST_CORRECT;
                end else begin
                    w_next = ST_WRONG;
                end
            end
            ST_CORRECT, ST_WRONG: begin
                w_tmr_en = 1'b1;
                if (!w_tmr_zero) begin
                    w_next = r_state;
                end else if (r_lives == {LIVES_W{1'b0}}) begin
                    w_next = ST_GAME_OVER;
                end else begin
                    w_next = ST_NEW_INSTR;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Score: cleared at game start, saturating increment on a correct judge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score <= {SCORE_W{1'b0}};
        end else if (w_game_start) begin
            r_score <= {SCORE_W{1'b0}};
        end else if ((r_state == ST_JUDGE) && answer && (r_score != SCORE_MAX)) begin
            r_score <= r_score + {{(SCORE_W-1){1'b0}}, 1'b1};
        end else begin
            r_score <= r_score;
        end
    end

    // Lives: reloaded at game start, saturating decrement on a wrong judge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lives <= LIVES_INIT;
        end else if (w_game_start) begin
            r_lives <= LIVES_INIT;
        end else if ((r_state == ST_JUDGE) && !answer && (r_lives != {LIVES_W{1'b0}})) begin
            r_lives <= r_lives - {{(LIVES_W-1){1'b0}}, 1'b1};
        end else begin
            r_lives <= r_lives;
        end
    end

    // Round flags: timeout marker and the wrong-answer pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_no_press      <= 1'b0;
            r_decrease_life <= 1'b0;
        end else begin
            r_decrease_life <= (r_state == ST_JUDGE) && !answer;
            if ((r_state == ST_WAIT_KEY) && (w_next == ST_JUDGE)) begin
                r_no_press <= 1'b1;
            end else if (w_next == ST_NEW_INSTR) begin
                r_no_press <= 1'b0;
            end else begin
                r_no_press <= r_no_press;
            end
        end
    end

    assign change_instruction = (r_state == ST_NEW_INSTR);
    assign prepare_judge      = (r_state == ST_WAIT_KEY) || (r_state == ST_KEY_HELD);
    assign judge_strobe       = (r_state == ST_JUDGE);
    assign fb_correct         = (r_state == ST_CORRECT);
    assign fb_wrong           = (r_state == ST_WRONG);
    assign game_over          = (r_state == ST_GAME_OVER);
    assign no_press           = r_no_press;
    assign decrease_life      = r_decrease_life;
    assign score              = r_score;
    assign lives              = r_lives;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: expected feedback results are queued at the
// judge cycle and compared when the feedback state appears.
module tb_game_ctrl;
    import game_pkg::*;

    localparam int LIVES = 3;
    localparam int A     = 8;
    localparam int F     = 4;
    localparam int SW    = 2;
    localparam int LW    = $clog2(LIVES + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          key_pressed = 1'b0;
    logic          answer = 1'b0;
    logic          change_instruction, prepare_judge, judge_strobe, no_press;
    logic          decrease_life, fb_correct, fb_wrong, game_over;
    logic [SW-1:0] score;
    logic [LW-1:0] lives;

    int n_pass = 0;
    int n_total = 0;

    logic [SW-1:0] exp_score;
    logic [LW-1:0] exp_lives;

    typedef struct packed {
        logic          correct;
        logic [SW-1:0] score;
        logic [LW-1:0] lives;
    } fb_exp_t;

    fb_exp_t sb_q[$];

    game_ctrl #(
        .LIVES        (LIVES),
        .ANSWER_CYC   (A),
        .FEEDBACK_CYC (F),
        .SCORE_W      (SW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .key_pressed        (key_pressed),
        .answer             (answer),
        .change_instruction (change_instruction),
        .prepare_judge      (prepare_judge),
        .judge_strobe       (judge_strobe),
        .no_press           (no_press),
        .decrease_life      (decrease_life),
        .fb_correct         (fb_correct),
        .fb_wrong           (fb_wrong),
        .score              (score),
        .lives              (lives),
        .game_over          (game_over)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
        exp_score = '0;
        exp_lives = LW'(LIVES);
        n_total++;
        if (change_instruction !== 1'b1) $display("FAIL start_ci: got %b exp 1", change_instruction);
        else n_pass++;
        n_total++;
        if (lives !== exp_lives || score !== exp_score)
            $display("FAIL start_reload: lives %0d score %0d exp %0d %0d", lives, score, exp_lives, exp_score);
        else n_pass++;
    endtask

    // Entered on the change_instruction cycle; press_at < 0 means no key.
    task automatic play_round(input int press_at, input int hold, input bit ans, input bit try_start);
        int n;
        bit bad;
        fb_exp_t e;
        if (press_at < 0) begin
            n = 0;
            tick;
            while (prepare_judge === 1'b1 && n < A + 4) begin
                n++;
                tick;
            end
            n_total++;
            if (n !== A) $display("FAIL answer_window: got %0d cycles exp %0d", n, A);
            else n_pass++;
            n_total++;
            if (judge_strobe !== 1'b1 || no_press !== 1'b1)
                $display("FAIL timeout_judge: strobe %b no_press %b exp 1 1", judge_strobe, no_press);
            else n_pass++;
        end else begin
            for (int i = 0; i < press_at; i++) tick;
            key_pressed = 1'b1;
            bad = 1'b0;
            for (int j = 0; j < hold; j++) begin
                tick;
                if (judge_strobe !== 1'b0 || prepare_judge !== 1'b1 || dut.r_state !== ST_KEY_HELD) bad = 1'b1;
            end
            n_total++;
            if (bad !== 1'b0) $display("FAIL key_held: left KEY_HELD while key down (got 1 exp 0)");
            else n_pass++;
            key_pressed = 1'b0;
            tick;
            n_total++;
            if (judge_strobe !== 1'b1 || no_press !== 1'b0)
                $display("FAIL release_judge: strobe %b no_press %b exp 1 0", judge_strobe, no_press);
            else n_pass++;
        end
        answer = ans;
        if (ans) exp_score = (exp_score == {SW{1'b1}}) ? exp_score : exp_score + 1'b1;
        else     exp_lives = (exp_lives == '0) ? exp_lives : exp_lives - 1'b1;
        e.correct = ans;
        e.score   = exp_score;
        e.lives   = exp_lives;
        sb_q.push_back(e);
        tick;
        answer = 1'b0;
        e = sb_q.pop_front();
        n_total++;
        if ({fb_correct, fb_wrong, decrease_life} !== {e.correct, ~e.correct, ~e.correct})
            $display("FAIL fb_entry: cor/wr/dec %b%b%b exp %b%b%b", fb_correct, fb_wrong, decrease_life,
                     e.correct, ~e.correct, ~e.correct);
        else n_pass++;
        n_total++;
        if (score !== e.score || lives !== e.lives)
            $display("FAIL fb_counters: score %0d lives %0d exp %0d %0d", score, lives, e.score, e.lives);
        else n_pass++;
        if (try_start) start = 1'b1;
        n = 1;
        tick;
        start = 1'b0;
        n_total++;
        if (decrease_life !== 1'b0 || change_instruction !== 1'b0 || lives !== e.lives || score !== e.score)
            $display("FAIL fb_second: dec %b ci %b lives %0d score %0d exp 0 0 %0d %0d",
                     decrease_life, change_instruction, lives, score, e.lives, e.score);
        else n_pass++;
        while ((fb_correct | fb_wrong) === 1'b1 && n < F + 4) begin
            n++;
            tick;
        end
        n_total++;
        if (n !== F) $display("FAIL feedback_len: got %0d exp %0d", n, F);
        else n_pass++;
        n_total++;
        if (e.lives == '0) begin
            if (game_over !== 1'b1) $display("FAIL to_game_over: got %b exp 1", game_over);
            else n_pass++;
        end else begin
            if (change_instruction !== 1'b1) $display("FAIL next_instr: got %b exp 1", change_instruction);
            else n_pass++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        n_total++;
        if ({change_instruction, prepare_judge, judge_strobe, no_press, decrease_life,
             fb_correct, fb_wrong, game_over, score} !== '0)
            $display("FAIL reset_outs: got nonzero outputs exp all 0");
        else n_pass++;
        n_total++;
        if (lives !== LW'(LIVES)) $display("FAIL reset_lives: got %0d exp %0d", lives, LIVES);
        else n_pass++;
        rst_n = 1'b1;
        tick;
        tick;
        n_total++;
        if (dut.r_state !== ST_IDLE || change_instruction !== 1'b0)
            $display("FAIL idle_hold: state %0d ci %b exp 0 0", dut.r_state, change_instruction);
        else n_pass++;
    endtask

    task automatic test_timeout;
        do_start;
        play_round(-1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_key_held;
        n_total++;
        if (no_press !== 1'b0) $display("FAIL no_press_clear: got %b exp 0", no_press);
        else n_pass++;
        play_round(2, 10, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_game;
        tick;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        exp_score = '0;
        exp_lives = LW'(LIVES);
        n_total++;
        if (dut.r_state !== ST_IDLE || prepare_judge !== 1'b0 || score !== exp_score || lives !== exp_lives)
            $display("FAIL async_reset: state %0d prep %b score %0d lives %0d exp 0 0 %0d %0d",
                     dut.r_state, prepare_judge, score, lives, exp_score, exp_lives);
        else n_pass++;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_game_over;
        do_start;
        for (int r = 0; r < LIVES; r++) play_round(2, 1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick;
        n_total++;
        if (game_over !== 1'b1 || lives !== '0 || score !== '0 || change_instruction !== 1'b0)
            $display("FAIL game_over_hold: go %b lives %0d score %0d ci %b exp 1 0 0 0",
                     game_over, lives, score, change_instruction);
        else n_pass++;
    endtask

    task automatic test_key_at_zero;
        do_start;
        play_round(A, 3, 1'b1, 1'b0);
    endtask

    task automatic test_saturation;
        for (int r = 0; r < 4; r++) play_round(1, 1, 1'b1, 1'b0);
        n_total++;
        if (score !== 2'd3) $display("FAIL score_sat: got %0d exp 3", score);
        else n_pass++;
    endtask

    initial begin
        exp_score = '0;
        exp_lives = LW'(LIVES);
        test_reset;
        test_timeout;
        test_key_held;
        test_reset_mid_game;
        test_game_over;
        test_key_at_zero;
        test_saturation;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Parametrised round controller for the NOT-NOT reaction game. It sequences instruction issue, the answer window, judging, and correct/wrong feedback. It owns the answer-window and feedback timers internally, with no external wait counter. It also tracks score and remaining lives, and enters a game-over state that only a fresh start request leaves. It sits between the keypad/edge logic and the instruction generator plus judge units.

## Interface
Parameters:
- LIVES, 3: lives loaded at game start; ≥1.
- ANSWER_CYC, 50_000_000: answer-window length in clk cycles; ≥2.
- FEEDBACK_CYC, 25_000_000: correct/wrong feedback length in cycles; ≥1.
- SCORE_W, 8: score width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: level; begins a game from IDLE or GAME_OVER.
- key_pressed, input, 1: level, high while any key held.
- answer, input, 1: judge result, valid in the JUDGE cycle; 1 = correct.
- change_instruction, output, 1: one-cycle pulse requesting a new instruction.
- prepare_judge, output, 1: high during WAIT_KEY and KEY_HELD.
- judge_strobe, output, 1: one-cycle pulse; judge output sampled this cycle.
- no_press, output, 1: registered; 1 if the current round ended by timeout. Cleared on change_instruction.
- decrease_life, output, 1: one-cycle pulse on a wrong answer.
- fb_correct, fb_wrong, output, 1 each: high throughout the respective feedback state.
- score, output, SCORE_W: correct answers this game.
- lives, output, $clog2(LIVES+1): remaining lives.
- game_over, output, 1: high in GAME_OVER.

## Operation
- States: IDLE, NEW_INSTR, WAIT_KEY, KEY_HELD, JUDGE, CORRECT, WRONG, GAME_OVER.
- IDLE: start → NEW_INSTR; loads lives=LIVES and score=0 on that transition.
- NEW_INSTR: one cycle; change_instruction=1; clears no_press; loads the timer with ANSWER_CYC-1 → WAIT_KEY.
- WAIT_KEY: timer decrements each cycle.
  - key_pressed → KEY_HELD.
  - Otherwise, timer==0 → JUDGE with no_press set.
  - key_pressed on the timer==0 cycle: the key wins.
- KEY_HELD: timer frozen; waits for release (key_pressed==0) → JUDGE. No timeout while held.
- JUDGE: one cycle; judge_strobe=1; samples answer.
  - answer=1 → CORRECT; score increments, saturating at all-ones.
  - answer=0 → WRONG; decrease_life pulses and lives decrements, saturating at 0.
  - Loads the timer with FEEDBACK_CYC-1.
- CORRECT/WRONG: hold until timer==0.
  - Then → GAME_OVER if lives==0; otherwise → NEW_INSTR.
- GAME_OVER: score and lives frozen. start → NEW_INSTR, reloading as in IDLE.
- start is ignored in every other state.
- Timer width is $clog2(max(ANSWER_CYC, FEEDBACK_CYC)). The down-counter holds at 0.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE; all outputs 0 except lives=LIVES.
- Registered state, decoded Moore outputs. No output depends combinationally on inputs.
- start→change_instruction: 1 cycle latency.
- Answer window: exactly ANSWER_CYC cycles in WAIT_KEY when no key is pressed.
- Feedback: exactly FEEDBACK_CYC cycles in CORRECT/WRONG.
- Release→judge_strobe: 1 cycle.
- judge_strobe→decrease_life: next cycle; decrease_life coincides with the first WRONG cycle.
- Lives and score update on the JUDGE→feedback edge.
- Reset asserted mid-game: immediate return to IDLE; score and lives reload.

## Structure
- Package game_pkg:
  - state enum game_state_t;
  - localparams for default cycle counts;
  - shared with the judge and instruction units.
- One sub-module, cycle_timer, is natural:
  - ports: load, load value, enable, zero flag;
  - used for both the answer window and feedback timing.
- The FSM, score counter and lives counter stay in game_ctrl.

## Test plan
- Reset, then start=1 one cycle:
  - change_instruction pulses on cycle 1 with lives=3 and score=0.
  - With no key pressed, judge_strobe fires exactly ANSWER_CYC cycles later and no_press=1.
- Press held for 10 cycles, answer=1:
  - judge_strobe fires 1 cycle after release.
  - score goes 0→1; fb_correct stays high for FEEDBACK_CYC cycles; change_instruction follows.
- Three consecutive answer=0 rounds (LIVES=3):
  - decrease_life pulses 3 times; lives goes 3→2→1→0.
  - game_over asserts after the third feedback.
  - start during feedback is ignored.
- key_pressed rising on the same cycle the timer reaches 0: enters KEY_HELD, no_press stays 0.
- SCORE_W=2 with 5 correct answers: score saturates at 3.
- rst_n low mid-WAIT_KEY: outputs return to reset values in the same cycle; state is IDLE.
